shared_reg_arbiter: RTL

SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

---
 rtl/shared_reg_arbiter_pkg.sv | 18 +
 rtl/shared_reg_arbiter_rr_picker.sv | 30 +++
 rtl/shared_reg_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/shared_reg_arbiter_pkg.sv
// rtl/shared_reg_arbiter_pkg.sv - shared types, defaults and helpers for the shared register arbiter
package shared_reg_arbiter_pkg;

   localparam int DEF_N = 4;
   localparam int DEF_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Rotating successor of a requester index, wrapping N-1 back to 0.
   function automatic int rr_next(input int sel, input int n);
      return (sel == n - 1) ? 0 : sel + 1;
   endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_picker.sv
// rtl/shared_reg_arbiter_rr_picker.sv - combinational round-robin picker starting from ptr
module rr_picker #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  winner,
   output logic [IW-1:0] win_idx,
   output logic          any
);

   always_comb begin
      int j;
      j       = 0;
      winner  = '0;
      win_idx = '0;
      any     = 1'b0;
      // Search ptr, ptr+1, ... wrapping; the first requester found wins.
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr) + k) % N;
         if (!any && req[j]) begin
            any       = 1'b1;
            winner[j] = 1'b1;
            win_idx   = IW'(j);
         end
      end
   end

endmodule

// File: rtl/shared_reg_arbiter.sv
// rtl/shared_reg_arbiter.sv - round-robin arbiter granting single writes into a shared register
module shared_reg_arbiter
   import shared_reg_arbiter_pkg::*;
#(
   parameter int N = DEF_N,
   parameter int W = DEF_W
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   input  logic [N*W-1:0] wdata,
   output logic [N-1:0]   grant,
   output logic [N-1:0]   ack,
   output logic [W-1:0]   q,
   output logic           busy
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   state_e        state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] sel_q, sel_d;
   logic [N-1:0]  grant_q, grant_d;
   logic [N-1:0]  ack_q, ack_d;
   logic [W-1:0]  q_q, q_d;
   logic          busy_q, busy_d;

   logic [N-1:0]  pick_winner;
   logic [IW-1:0] pick_idx;
   logic          pick_any;

   rr_picker #(
      .N  (N),
      .IW (IW)
   ) u_picker (
      .req     (req),
      .ptr     (ptr_q),
      .winner  (pick_winner),
      .win_idx (pick_idx),
      .any     (pick_any)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      grant_d = grant_q;
      ack_d   = '0;
      q_d     = q_q;
      case (state_q)
         ST_IDLE: begin
            grant_d = '0;
            if (pick_any) begin
               grant_d = pick_winner;
               sel_d   = pick_idx;
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            // Grant stays up through DONE so ack is always covered by grant.
            if (req[sel_q]) begin
               q_d          = wdata[int'(sel_q)*W +: W];
               ack_d[sel_q] = 1'b1;
               ptr_d        = IW'(rr_next(int'(sel_q), N));
               state_d      = ST_DONE;
            end else begin
               grant_d = '0;
               state_d = ST_IDLE;
            end
         end
         ST_DONE: begin
            grant_d = '0;
            state_d = ST_IDLE;
         end
         default: begin
            grant_d = '0;
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         sel_q   <= '0;
         grant_q <= '0;
         ack_q   <= '0;
         q_q     <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         grant_q <= grant_d;
         ack_q   <= ack_d;
         q_q     <= q_d;
         busy_q  <= busy_d;
      end
   end

   assign grant = grant_q;
   assign ack   = ack_q;
   assign q     = q_q;
   assign busy  = busy_q;

endmodule
